// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry {pc, instr} buffer.
// Define IF_PERF_CNT_EN to add the fetch_count / flush_count performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entryT;

  logic [1:0]  state;
  logic [31:0] fetchPc;
  logic [31:0] reqAddr;
  logic [1:0]  entryCount;
  entryT       headEntry;
  entryT       tailEntry;
  entryT       newEntry;
  logic        issue;
  logic        accept;
  logic        pop;

  // A new request leaves IDLE only with buffer room, so a push can never overflow.
  assign issue     = (state == IDLE) && (entryCount != 2'd2) && !redirect && !rst;
  assign accept    = (state == WAIT) && imem_ack && !redirect;
  assign pop       = instr_valid && !stall && !redirect;
  assign newEntry  = {fetchPc + 32'd1, imem_data};

  assign imem_req    = issue || (state == WAIT) || (state == DRAIN);
  assign imem_addr   = (state == IDLE) ? fetchPc : reqAddr;
  assign instr_valid = (entryCount != 2'd0);
  assign instr       = headEntry.instr;
  assign pc          = headEntry.pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
      reqAddr <= RESET_PC;
    end else begin
      if (redirect) begin
        fetchPc <= redirect_target;
      end else if (accept) begin
        fetchPc <= fetchPc + 32'd1;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            state   <= WAIT;
            reqAddr <= fetchPc;
          end
        end
        WAIT: begin
          if (imem_ack)      state <= IDLE;
          else if (redirect) state <= DRAIN;
        end
        DRAIN: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entryCount <= 2'd0;
    end else if (redirect) begin
      entryCount <= 2'd0;
    end else if (accept && !pop) begin
      entryCount <= entryCount + 2'd1;
    end else if (pop && !accept) begin
      entryCount <= entryCount - 2'd1;
    end
  end

  // The head register doubles as the output register, so it resets to drive zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headEntry <= '0;
    end else if (accept && ((entryCount == 2'd0) || (entryCount == 2'd1 && pop))) begin
      headEntry <= newEntry;
    end else if (pop && entryCount == 2'd2) begin
      headEntry <= tailEntry;
    end
  end

  // NOTE: the tail slot is storage only; entryCount qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && ((entryCount == 2'd1 && !pop) || (entryCount == 2'd2 && pop))) begin
      tailEntry <= newEntry;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (accept)   fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable memory that returns data = address.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  // Memory model state; manual ack overrides the model when memEn is low.
  logic        memEn;
  int          memLat;
  logic        ackModel, ackMan;
  logic [31:0] dataModel, dataMan;
  logic        pend;
  int          cnt;
  logic [31:0] pAddr;
  logic [31:0] reqQ[$];
  logic [63:0] outQ[$];

  int checks = 0;
  int errors = 0;

  assign imem_ack  = memEn ? ackModel : ackMan;
  assign imem_data = memEn ? dataModel : dataMan;

  instr_fetch #(.RESET_PC(32'h0000_0010)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr           (instr),
    .pc              (pc),
    .instr_valid     (instr_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory: captures each new request late in the cycle, acks memLat cycles later with data = addr.
  // The same process logs every head entry consumed by decode.
  initial begin
    ackModel = 1'b0; dataModel = '0; pend = 1'b0; cnt = 0; pAddr = '0;
    forever begin
      @(posedge clk); #1;
      ackModel = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          ackModel = 1'b1; dataModel = pAddr; pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      @(negedge clk); #3;
      if (memEn && imem_req && !imem_ack && !pend) begin
        reqQ.push_back(imem_addr);
        pend = 1'b1; cnt = memLat; pAddr = imem_addr;
      end
      if (instr_valid && !stall && !redirect) outQ.push_back({pc, instr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] outAt(int i);
    return (outQ.size() > i) ? outQ[i] : '1;
  endfunction

  function automatic logic [31:0] reqAt(int i);
    return (reqQ.size() > i) ? reqQ[i] : '1;
  endfunction

  task automatic waitPendRise(input string name);
    bit seenLow = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #4;
      if (!pend) seenLow = 1'b1;
      else if (seenLow) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no new request within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    memEn = 1'b1; memLat = 1; ackMan = 1'b0; dataMan = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rst_addr: got %h want 00000010", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_fetch;
    reqQ.delete(); outQ.delete();
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10})
      begin errors++; $display("FAIL first_req: got %b/%h want 1/00000010", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b want 0", instr_valid); end
    @(negedge clk); #1;
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h11, 32'h10})
      begin errors++; $display("FAIL ack_latency: got %b/%h/%h want 1/00000011/00000010", instr_valid, pc, instr); end
    repeat (8) @(negedge clk);
    #4;
    checks++; if (reqAt(0) !== 32'h10) begin errors++; $display("FAIL req0: got %h want 00000010", reqAt(0)); end
    checks++; if (reqAt(1) !== 32'h11) begin errors++; $display("FAIL req1: got %h want 00000011", reqAt(1)); end
    checks++; if (reqAt(2) !== 32'h12) begin errors++; $display("FAIL req2: got %h want 00000012", reqAt(2)); end
    checks++; if (outAt(0) !== {32'h11, 32'h10}) begin errors++; $display("FAIL out0: got %h want 0000001100000010", outAt(0)); end
    checks++; if (outAt(1) !== {32'h12, 32'h11}) begin errors++; $display("FAIL out1: got %h want 0000001200000011", outAt(1)); end
  endtask

  task automatic test_stall;
    logic [63:0] lastPop;
    logic [31:0] sp, si;
    int reqSeen = 0;
    int changed = 0;
    @(negedge clk); stall = 1'b1;
    lastPop = (outQ.size() > 0) ? outQ[$] : '1;
    repeat (8) @(negedge clk);
    #1;
    sp = pc; si = instr;
    checks++; if (sp !== lastPop[63:32] + 32'd1)
      begin errors++; $display("FAIL stall_head: got pc %h want %h", sp, lastPop[63:32] + 32'd1); end
    checks++; if (si !== sp - 32'd1) begin errors++; $display("FAIL stall_pair: got instr %h want %h", si, sp - 32'd1); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (imem_req) reqSeen++;
      if ({instr_valid, pc, instr} !== {1'b1, sp, si}) changed++;
    end
    checks++; if (reqSeen !== 0) begin errors++; $display("FAIL full_no_req: got %0d request cycles want 0", reqSeen); end
    checks++; if (changed !== 0) begin errors++; $display("FAIL stall_hold: got %0d changed cycles want 0", changed); end
    outQ.delete();
    @(negedge clk); stall = 1'b0;
    @(negedge clk); #1;
    checks++; if ({instr_valid, pc} !== {1'b1, sp + 32'd1})
      begin errors++; $display("FAIL second_entry: got %b/%h want 1/%h", instr_valid, pc, sp + 32'd1); end
    repeat (6) @(negedge clk);
    #4;
    checks++; if (outAt(0) !== {sp, si}) begin errors++; $display("FAIL drain0: got %h want %h", outAt(0), {sp, si}); end
    checks++; if (outAt(1) !== {sp + 32'd1, si + 32'd1})
      begin errors++; $display("FAIL drain1: got %h want %h", outAt(1), {sp + 32'd1, si + 32'd1}); end
    checks++; if (outAt(2) !== {sp + 32'd2, si + 32'd2})
      begin errors++; $display("FAIL drain2: got %h want %h", outAt(2), {sp + 32'd2, si + 32'd2}); end
  endtask

  task automatic test_redirect_wait;
    logic [31:0] oldAddr;
    memLat = 3;
    waitPendRise("redir_wait_sync");
    oldAddr = pAddr;
    @(negedge clk); redirect = 1'b1; redirect_target = 32'h40;
    reqQ.delete(); outQ.delete();
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, oldAddr})
      begin errors++; $display("FAIL drain_hold: got %b/%b/%h want 0/1/%h", instr_valid, imem_req, imem_addr, oldAddr); end
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40})
      begin errors++; $display("FAIL drain_discard: got %b/%b/%h want 0/1/00000040", instr_valid, imem_req, imem_addr); end
    repeat (8) @(negedge clk);
    #4;
    checks++; if (reqAt(0) !== 32'h40) begin errors++; $display("FAIL redir_req: got %h want 00000040", reqAt(0)); end
    checks++; if (outAt(0) !== {32'h41, 32'h40}) begin errors++; $display("FAIL redir_out: got %h want 0000004100000040", outAt(0)); end
  endtask

  task automatic test_redirect_ack;
    waitPendRise("redir_ack_sync");
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({imem_ack, instr_valid} !== 2'b11)
      begin errors++; $display("FAIL redir_ack_pre: got ack %b valid %b want 1 1", imem_ack, instr_valid); end
    redirect = 1'b1; redirect_target = 32'h80;
    @(negedge clk); redirect = 1'b0; stall = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_ack_flush: got %b want 0", instr_valid); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h80})
      begin errors++; $display("FAIL redir_ack_req: got %b/%h want 1/00000080", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    memLat = 1;
    @(negedge clk); redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    reqQ.delete(); outQ.delete();
    @(negedge clk); redirect = 1'b0;
    repeat (12) @(negedge clk);
    #4;
    checks++; if (reqAt(0) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_req0: got %h want ffffffff", reqAt(0)); end
    checks++; if (reqAt(1) !== 32'h0) begin errors++; $display("FAIL wrap_req1: got %h want 00000000", reqAt(1)); end
    checks++; if (outAt(0) !== {32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL wrap_out0: got %h want 00000000ffffffff", outAt(0)); end
    checks++; if (outAt(1) !== {32'h1, 32'h0}) begin errors++; $display("FAIL wrap_out1: got %h want 0000000100000000", outAt(1)); end
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    @(negedge clk); memEn = 1'b0; ackMan = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (imem_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL mid_sync: no request within 20 cycles"); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if ({imem_req, instr_valid, imem_addr} !== {1'b0, 1'b0, 32'h10})
      begin errors++; $display("FAIL mid_rst: got %b/%b/%h want 0/0/00000010", imem_req, instr_valid, imem_addr); end
    @(negedge clk);
    @(negedge clk); rst = 1'b0; ackMan = 1'b1; dataMan = 32'hDEAD_BEEF; #1;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10})
      begin errors++; $display("FAIL post_rst_req: got %b/%h want 1/00000010", imem_req, imem_addr); end
    @(negedge clk); ackMan = 1'b0; #1;
    checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10})
      begin errors++; $display("FAIL late_ack_ignored: got %b/%b/%h want 0/1/00000010", instr_valid, imem_req, imem_addr); end
    ackMan = 1'b1; dataMan = 32'h1234_5678;
    @(negedge clk); ackMan = 1'b0; #1;
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h11, 32'h1234_5678})
      begin errors++; $display("FAIL post_rst_data: got %b/%h/%h want 1/00000011/12345678", instr_valid, pc, instr); end
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL fetch_count: got %0d want 1", fetch_count); end
    checks++; if (flush_count !== 32'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", flush_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
